// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// codes, FSM states and the decoder funct/ALU-control constants that route
// instructions to it.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MULT  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam logic [2:0] ALUCTL_MULDIV = 3'b100;

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO registers. A completing operation overrides any
// MTHI/MTLO write presented on the same edge.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_we_i,
  input  logic [WIDTH-1:0] cmp_hi_i,
  input  logic [WIDTH-1:0] cmp_lo_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Write-priority mux: completion result first, then MT writes.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cmp_we_i) begin
      hi_d = cmp_hi_i;
      lo_d = cmp_lo_i;
    end else begin
      if (wr_hi_i) hi_d = wdata_i;
      if (wr_lo_i) lo_d = wdata_i;
    end
  end

  // HI/LO state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add MULTU and restoring DIVU, one
// iteration per cycle, results landing in HI/LO on the final edge.
// Optional macro MULDIV_SIGNED_EN adds MULT/DIV by working on operand
// magnitudes and fixing result signs on the completion edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, shl_rem;
  logic [2*WIDTH-1:0] acc_it;
  logic [WIDTH:0]     rem_it;
  logic               div_zero, last;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [2*WIDTH-1:0] prod_neg;
  assign sa_d  = op[1] & a[WIDTH-1];
  assign sb_d  = op[1] & b[WIDTH-1];
  assign a_mag = sa_d ? -a : a;
  assign b_mag = sb_d ? -b : b;
`else
  logic unused_op;
  assign unused_op = op[1];
  assign a_mag     = a;
  assign b_mag     = b;
`endif

  // One multiply or divide iteration on the working registers.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    shl_rem = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    if (div_q) begin
      if (shl_rem >= {1'b0, b_q}) begin
        rem_it = shl_rem - {1'b0, b_q};
        acc_it = {acc_q[2*WIDTH-2:0], 1'b1};
      end else begin
        rem_it = shl_rem;
        acc_it = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_it = rem_q;
      acc_it = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign div_zero = div_q && (b_q == '0);
  assign last     = (state_q == RUN) && (div_zero || (cnt_q == CNT_W'(WIDTH - 1)));

  // Final HI/LO values formed from the last iteration's output.
  always_comb begin
    res_lo = acc_it[WIDTH-1:0];
    res_hi = div_q ? rem_it[WIDTH-1:0] : acc_it[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
    prod_neg = -acc_it;
    if (div_q) begin
      if (sa_q ^ sb_q) res_lo = -res_lo;
      if (sa_q)        res_hi = -res_hi;
    end else if (sa_q ^ sb_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
`endif
    if (div_zero) begin
      res_lo = '1;
      res_hi = a_q;
`ifdef MULDIV_SIGNED_EN
      if (sa_q) res_hi = -a_q;
`endif
    end
  end

  // Next-state logic: capture in IDLE/DONE, iterate in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      RUN: begin
        acc_d = acc_it;
        rem_d = rem_it;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = op[0];
          a_d     = a_mag;
          b_d     = b_mag;
          rem_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, (op[0] ? a_mag : b_mag)};
        end
      end
    endcase
  end

  // FSM and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Operand sign flags, held for the result fix-up on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (start && (state_q != RUN)) begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  muldiv_hilo #(.WIDTH(WIDTH)) u_hilo (
    .clk      (clk),
    .rst      (reset),
    .cmp_we_i (last),
    .cmp_hi_i (res_hi),
    .cmp_lo_i (res_lo),
    .wr_hi_i  (wr_hi),
    .wr_lo_i  (wr_lo),
    .wdata_i  (wdata),
    .hi_o     (hi),
    .lo_o     (lo)
  );

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Executes the MULTU/DIVU operations the decoder routes to ALU control 3'b100.
- Provides the HI/LO values read by MFHI/MFLO and written by MTHI/MTLO.
- Sits beside the ALU in the datapath; the controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; not to be overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  2  operation code: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV (10/11 only with MULDIV_SIGNED_EN).
- a  in  WIDTH  multiplicand or dividend; captured when start is accepted.
- b  in  WIDTH  multiplier or divisor; captured when start is accepted.
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wdata  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, hi=0, lo=0, busy=0, done=0, counter and working registers 0. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → capture a, b and op; counter=0; go to RUN.
  - RUN: one iteration per cycle. After the WIDTH-th iteration, write the result to hi/lo on that same edge and go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 → behave as in IDLE (back-to-back issue). Otherwise go to IDLE.
- busy=1 exactly in RUN. start during RUN is ignored (not queued).
- Latency: start accepted at edge E0 → busy in cycles E0..E_WIDTH → hi/lo valid and done=1 in the cycle after edge E_WIDTH. Issue-to-done is WIDTH+1 cycles.
- MULTU: shift-add over a 2*WIDTH accumulator; {hi,lo} = a*b, full-width unsigned product, no truncation.
- DIVU: restoring division with a WIDTH+1-bit partial remainder; lo = a/b, hi = a%b.
- Divide by zero (b=0, DIVU/DIV):
  - Completes via RUN→DONE in 1 cycle instead of WIDTH.
  - lo = all ones, hi = a.
  - No exception.
- hi/lo change only at completion or on MT writes; MFHI/MFLO during RUN read the previous values.
- wr_hi/wr_lo take effect on the next edge in any state.
  - Same-edge conflict with completion: completion wins.
  - wr_hi and wr_lo together: both written with wdata.
  - MT write in the same cycle as start: the write applies and the operation is accepted.
- op 10/11 without MULDIV_SIGNED_EN: treated as 00/01.

Optional Feature:
- MULDIV_SIGNED_EN defined: MULT/DIV supported.
  - Operands are converted to magnitudes at capture; result signs are fixed on the completion edge. No added latency.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1: lo = a, hi = 0.
  - Signed divide by zero follows the same rule as unsigned.
- Not defined: sign-handling logic absent; op[1] ignored.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MULTU, MD_DIVU, MD_MULT, MD_DIV.
  - state enum IDLE/RUN/DONE.
  - decoder funct constants for MULTU/DIVU/MFHI/MFLO/MTHI/MTLO.
- One natural sub-module: muldiv_hilo, holding the HI/LO registers and the write-priority mux (completion > MT write).

Test Plan:
- MULTU, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF → done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- DIVU: a=100, b=7 → lo=14, hi=2. Then back-to-back start asserted in the DONE cycle with a=7, b=100 → lo=0, hi=7 with no idle cycle between.
- DIVU by zero: a=0x12345678, b=0 → done 2 cycles after start; lo=0xFFFFFFFF, hi=0x12345678.
- Reset asserted mid-RUN (iteration 10) → hi=lo=0 and busy=0 immediately, without waiting for a clock; no done pulse afterwards.
- MTHI of 0xAAAA5555 on the completion edge of MULTU 3*5 → hi=0, lo=15 (completion wins). MTLO 0x1 in IDLE → lo=1 next cycle.
- With MULDIV_SIGNED_EN, DIV a=-7, b=2 → lo=-3, hi=-1. WIDTH=8 instance: MULTU 200*200 → {hi,lo}=0x9C40, done after 9 cycles.
